// File: rtl/stego_pkg.sv
// rtl/stego_pkg.sv - shared constants, FSM states and trit codes for the stego decode stage
package stego_pkg;

  localparam int IMG_DIM = 64;
  localparam int BLK     = 4;
  localparam int WORD_W  = 16;
  localparam int TRITS   = 14;

  localparam int ADDR_W = $clog2(IMG_DIM);
  localparam int PIX_W  = $clog2(BLK * BLK);
  localparam int BLK_W  = 2 * $clog2(IMG_DIM / BLK);
  localparam int WGT_W  = 22;
  localparam int ACC_W  = WGT_W + 1;

  // Trit codes, shared with the encode stage.
  localparam logic [1:0] TRIT_ZERO  = 2'd0;
  localparam logic [1:0] TRIT_PLUS  = 2'd1;
  localparam logic [1:0] TRIT_MINUS = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EXTRACT,
    ST_EMIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/trit_accumulator.sv
// rtl/trit_accumulator.sv - base-3 to binary accumulator, least-significant trit first
module trit_accumulator
  import stego_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              trit_valid,
  input  logic [1:0]        trit,
  output logic [WORD_W-1:0] acc_lo,
  output logic              overflow
);

  logic [ACC_W-1:0] acc_q, acc_d, addend;
  logic [WGT_W-1:0] wgt_q, wgt_d;
  logic [4:0]       cnt_q, cnt_d;

  always_comb begin
    acc_d  = acc_q;
    wgt_d  = wgt_q;
    cnt_d  = cnt_q;
    addend = '0;
    if (clear) begin
      acc_d = '0;
      wgt_d = WGT_W'(1);
      cnt_d = '0;
    end else if (trit_valid && (cnt_q < 5'(TRITS))) begin
      case (trit)
        TRIT_PLUS:  addend = {1'b0, wgt_q};
        TRIT_MINUS: addend = {wgt_q, 1'b0};
        default:    addend = '0;
      endcase
      acc_d = acc_q + addend;
      // weight *= 3 as w + 2w; the wrap after the last trit is never used
      wgt_d = wgt_q + {wgt_q[WGT_W-2:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      wgt_q <= WGT_W'(1);
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      wgt_q <= wgt_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_lo   = acc_q[WORD_W-1:0];
  assign overflow = |acc_q[ACC_W-1:WORD_W];

endmodule

// File: rtl/stego_decode.sv
// rtl/stego_decode.sv - recovers one 16-bit word per 4x4 stego block, 33 cycles per block
// Optional DECODE_STRICT_CHECK_EN: also flag skipped-pixel mismatches and words above 16 bits.
module stego_decode
  import stego_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  input  logic [23:0]       cover_pix,
  input  logic [23:0]       stego_pix,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [BLK_W-1:0]  word_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic [PIX_W-1:0]  pix_q, pix_d, second_q, second_d;
  logic [7:0]        ref_q, ref_d;
  logic              found_q, found_d;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic [BLK_W-1:0]  word_idx_q, word_idx_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [7:0]        cover_g, stego_g;
  logic [8:0]        diff;
  logic              skip, trit_valid, acc_clear, acc_ovf;
  logic [1:0]        trit;
  logic [WORD_W-1:0] acc_lo;
  logic              unused_bits;

  assign cover_g = cover_pix[15:8];
  assign stego_g = stego_pix[15:8];
  assign diff    = {1'b0, stego_g} - {1'b0, cover_g};
  assign skip    = (pix_q == '0) || (pix_q == second_q);

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    pix_d        = pix_q;
    second_d     = second_q;
    ref_d        = ref_q;
    found_d      = found_q;
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    word_idx_d   = word_idx_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    trit_valid   = 1'b0;
    trit         = TRIT_ZERO;
    acc_clear    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_SCAN;
          blk_d     = '0;
          pix_d     = '0;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          acc_clear = 1'b1;
        end
      end
      ST_SCAN: begin
        if (pix_q == '0) begin
          ref_d    = cover_g;
          found_d  = 1'b0;
          second_d = PIX_W'(1);
        end else if (!found_q && (cover_g != ref_q)) begin
          second_d = pix_q;
          found_d  = 1'b1;
        end
        pix_d = pix_q + PIX_W'(1);
        if (pix_q == '1) state_d = ST_EXTRACT;
      end
      ST_EXTRACT: begin
        if (skip) begin
`ifdef DECODE_STRICT_CHECK_EN
          if (stego_g != cover_g) err_d = 1'b1;
`endif
        end else begin
          trit_valid = 1'b1;
          case (diff)
            9'h000:  trit = TRIT_ZERO;
            9'h001:  trit = TRIT_PLUS;
            9'h1FF:  trit = TRIT_MINUS;
            default: begin
              trit  = TRIT_ZERO;
              err_d = 1'b1;
            end
          endcase
        end
        pix_d = pix_q + PIX_W'(1);
        if (pix_q == '1) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        word_valid_d = 1'b1;
        word_data_d  = acc_lo;
        word_idx_d   = blk_q;
        acc_clear    = 1'b1;
`ifdef DECODE_STRICT_CHECK_EN
        if (acc_ovf) err_d = 1'b1;
`endif
        blk_d = blk_q + BLK_W'(1);
        if (blk_q == '1) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      blk_q        <= '0;
      pix_q        <= '0;
      second_q     <= '0;
      ref_q        <= '0;
      found_q      <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      pix_q        <= pix_d;
      second_q     <= second_d;
      ref_q        <= ref_d;
      found_q      <= found_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_idx_q   <= word_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  trit_accumulator u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (acc_clear),
    .trit_valid (trit_valid),
    .trit       (trit),
    .acc_lo     (acc_lo),
    .overflow   (acc_ovf)
  );

  // Block index splits into block row (upper half) and block column (lower half).
  assign row        = {blk_q[BLK_W-1:BLK_W/2], pix_q[PIX_W-1:PIX_W/2]};
  assign col        = {blk_q[BLK_W/2-1:0], pix_q[PIX_W/2-1:0]};
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign word_idx   = word_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

`ifdef DECODE_STRICT_CHECK_EN
  assign unused_bits = ^{cover_pix[23:16], cover_pix[7:0], stego_pix[23:16], stego_pix[7:0]};
`else
  assign unused_bits = ^{cover_pix[23:16], cover_pix[7:0], stego_pix[23:16], stego_pix[7:0], acc_ovf};
`endif

endmodule

// File: tb/tb_stego_decode.sv
// tb/tb_stego_decode.sv - randomized image passes checked against a behavioural decode model
module tb_stego_decode;

  localparam int PASS_CYC = 8448;
  localparam int NEVER    = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [5:0]  row, col;
  logic [23:0] cover_pix, stego_pix;
  logic        word_valid;
  logic [15:0] word_data;
  logic [7:0]  word_idx;
  logic        busy, done, err;

  int checks = 0;
  int failures = 0;

  logic [7:0]  cov [64][64];
  logic [7:0]  stg [64][64];
  int          exp_word [256];
  logic [15:0] got_word [256];
  int          err_cycle;

  stego_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .row        (row),
    .col        (col),
    .cover_pix  (cover_pix),
    .stego_pix  (stego_pix),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Junk in the non-gray bits must be ignored by the decoder.
  assign cover_pix = {row, 2'b10, cov[row][col], col, 2'b01};
  assign stego_pix = {col, 2'b01, stg[row][col], row, 2'b11};

  function automatic int pr(input int b, input int p);
    return (b / 16) * 4 + p / 4;
  endfunction

  function automatic int pc(input int b, input int p);
    return (b % 16) * 4 + p % 4;
  endfunction

  function automatic int find_second(input int b);
    for (int p = 1; p < 16; p++)
      if (cov[pr(b, p)][pc(b, p)] != cov[pr(b, 0)][pc(b, 0)]) return p;
    return 1;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic embed(input int b, input int word);
    int sec, w, t;
    w = word;
    sec = find_second(b);
    for (int p = 0; p < 16; p++) begin
      stg[pr(b, p)][pc(b, p)] = cov[pr(b, p)][pc(b, p)];
      if (p != 0 && p != sec) begin
        t = w % 3;
        w = w / 3;
        if (t == 1) stg[pr(b, p)][pc(b, p)] = cov[pr(b, p)][pc(b, p)] + 8'd1;
        else if (t == 2) stg[pr(b, p)][pc(b, p)] = cov[pr(b, p)][pc(b, p)] - 8'd1;
      end
    end
  endtask

  task automatic fill_block(input int b, input int v0, input int vrest);
    for (int p = 0; p < 16; p++) begin
      cov[pr(b, p)][pc(b, p)] = (p == 0) ? 8'(v0) : 8'(vrest);
      stg[pr(b, p)][pc(b, p)] = cov[pr(b, p)][pc(b, p)];
    end
  endtask

  task automatic fill_random();
    int lo, hi;
    for (int b = 0; b < 256; b++) begin
      lo = $urandom_range(1, 200);
      hi = lo + $urandom_range(0, 54);
      for (int p = 0; p < 16; p++)
        cov[pr(b, p)][pc(b, p)] = ($urandom_range(0, 1) == 1) ? 8'(hi) : 8'(lo);
      embed(b, $urandom_range(0, 65535));
    end
  endtask

  // Decode the stored images from the rules: skip (0,0) and the first differing
  // pixel, read +1/-1/0 as trits LSB first, and note the cycle err must rise.
  task automatic model();
    int sec, d, t, acc, wt;
    err_cycle = NEVER;
    for (int b = 0; b < 256; b++) begin
      sec = find_second(b);
      acc = 0;
      wt  = 1;
      for (int p = 0; p < 16; p++) begin
        d = int'(stg[pr(b, p)][pc(b, p)]) - int'(cov[pr(b, p)][pc(b, p)]);
        if (p == 0 || p == sec) begin
`ifdef DECODE_STRICT_CHECK_EN
          if (d != 0) err_cycle = min_int(err_cycle, 33 * b + 17 + p);
`endif
        end else begin
          if (d == 0) t = 0;
          else if (d == 1) t = 1;
          else if (d == -1) t = 2;
          else begin
            t = 0;
            err_cycle = min_int(err_cycle, 33 * b + 17 + p);
          end
          acc = acc + t * wt;
          wt  = wt * 3;
        end
      end
      exp_word[b] = acc % 65536;
`ifdef DECODE_STRICT_CHECK_EN
      if (acc > 65535) err_cycle = min_int(err_cycle, 33 * (b + 1));
`endif
    end
  endtask

  task automatic run_pass(input string name, input bit poke_start);
    int bad_valid, bad_idx, bad_busy, bad_done, bad_err;
    bit ev;
    bad_valid = 0; bad_idx = 0; bad_busy = 0; bad_done = 0; bad_err = 0;
    for (int k = 0; k < 256; k++) got_word[k] = 'x;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c <= PASS_CYC + 2; c++) begin
      if (poke_start && c == 100) start = 1'b1;
      if (poke_start && c == 101) start = 1'b0;
      ev = (c >= 33) && (c <= PASS_CYC) && (c % 33 == 0);
      if (word_valid !== ev) bad_valid++;
      if (ev && word_valid === 1'b1) begin
        got_word[c / 33 - 1] = word_data;
        if (word_idx !== 8'(c / 33 - 1)) bad_idx++;
      end
      if (busy !== (c < PASS_CYC)) bad_busy++;
      if (done !== (c >= PASS_CYC)) bad_done++;
      if (err !== (c >= err_cycle)) bad_err++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (bad_valid != 0) begin
      failures++;
      $display("FAIL %s word_valid_timing: %0d bad cycles, required 0", name, bad_valid);
    end
    checks++;
    if (bad_idx != 0) begin
      failures++;
      $display("FAIL %s word_idx: %0d bad words, required 0", name, bad_idx);
    end
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL %s busy: %0d bad cycles, required 0", name, bad_busy);
    end
    checks++;
    if (bad_done != 0) begin
      failures++;
      $display("FAIL %s done: %0d bad cycles, required 0", name, bad_done);
    end
    checks++;
    if (bad_err != 0) begin
      failures++;
      $display("FAIL %s err: %0d bad cycles (err expected from cycle %0d), required 0", name, bad_err, err_cycle);
    end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (got_word[k] !== 16'(exp_word[k])) begin
        failures++;
        $display("FAIL %s word_data[%0d]: got %h, required %h", name, k, got_word[k], 16'(exp_word[k]));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (row !== 6'd0) begin failures++; $display("FAIL reset_row: got %0d, required 0", row); end
    checks++; if (col !== 6'd0) begin failures++; $display("FAIL reset_col: got %0d, required 0", col); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid: got %b, required 0", word_valid); end
    checks++; if (word_data !== 16'd0) begin failures++; $display("FAIL reset_word_data: got %h, required 0", word_data); end
    checks++; if (word_idx !== 8'd0) begin failures++; $display("FAIL reset_word_idx: got %0d, required 0", word_idx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b, required 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_uniform();
    for (int b = 0; b < 256; b++) fill_block(b, 100, 100);
    model();
    run_pass("uniform", 1'b0);
  endtask

  task automatic test_embed();
    fill_random();
    fill_block(0, 50, 80);
    stg[0][2] = 8'd81;
    embed(37, 16'hBEEF);
    model();
    run_pass("embed", 1'b0);
    checks++;
    if (got_word[0] !== 16'h0001) begin
      failures++;
      $display("FAIL embed_block0_plus1: got %h, required 0001", got_word[0]);
    end
    checks++;
    if (got_word[37] !== 16'hBEEF) begin
      failures++;
      $display("FAIL embed_block37_beef: got %h, required beef", got_word[37]);
    end
  endtask

  task automatic test_errors();
    fill_random();
    fill_block(0, 100, 200);
    for (int p = 2; p < 16; p++) stg[pr(0, p)][pc(0, p)] = 8'd199;
    fill_block(5, 120, 120);
    embed(5, $urandom_range(0, 65535));
    stg[pr(5, 3)][pc(5, 3)] = 8'd122;
    model();
    run_pass("errors", 1'b1);
    checks++;
    if (got_word[0] !== 16'hFB78) begin
      failures++;
      $display("FAIL errors_all_minus_one: got %h, required fb78", got_word[0]);
    end
  endtask

  task automatic test_reset_midpass();
    int bad;
    fill_random();
    stg[pr(200, 0)][pc(200, 0)] = cov[pr(200, 0)][pc(200, 0)] + 8'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({row, col, word_valid, word_data, word_idx, busy, done, err} !== 41'd0) begin
      failures++;
      $display("FAIL midpass_reset_outputs: got %h, required 0",
               {row, col, word_valid, word_data, word_idx, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (word_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midpass_idle_after_reset: %0d active cycles, required 0", bad);
    end
    model();
    run_pass("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_embed();
    test_errors();
    test_reset_midpass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
